mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline memory stage directly downstream of the execute stage.
- Accepts one plr_m record per handshake and performs the data-bus access for OP_LW/OP_SW.
- Produces a plr_w record for write-back.
- Holds at most one instruction; stalls upstream while a bus transaction is outstanding.

Parameters:
ADDR_ALIGN_CHECK, 1, when 1 a misaligned LW/SW (addr[1:0]!=0) raises an address-error stat instead of accessing the bus

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  execute offers a plr_m record
in_ready  out  1  stage can accept this cycle
in_m  in  plr_m  record from execute (dstE, dstM, valA, valE, stat, opcode, funct, pc)
out_valid  out  1  plr_w record available
out_ready  in  1  write-back consumes this cycle
out_w  out  plr_w  record to write-back (dstE, dstM, valE, valM, stat, opcode, pc)
dreq_valid  out  1  data request valid
dreq_addr  out  32  byte address (= valE)
dreq_strobe  out  4  byte enables; 4'hF for SW, 0 for LW
dreq_data  out  32  store data (= valA)
dresp_addr_ok  in  1  bus accepted request
dresp_data_ok  in  1  bus completed transaction
dresp_data  in  32  load data

Behaviour:
- One clock; reset is asynchronous and active-high on port reset. Clock port is clk.
- Reset: state=EMPTY, out_valid=0, dreq_valid=0, dreq_strobe=0, internal record cleared to '0, in_ready=1.
- States:
  - EMPTY
  - REQ: dreq_valid high
  - WAIT: addr accepted, data pending
  - FULL: out_w valid
- in_ready = (state==EMPTY) | (state==FULL & out_ready). Capture in_m when in_valid & in_ready.
- Captured non-memory op, or memory op with alignment fault: go to FULL next cycle (1-cycle latency).
  - valM=0.
  - On a fault, stat gets the address-error code from the shared package and no bus request is issued.
- Captured LW/SW: go to REQ.
  - dreq_valid, dreq_addr, dreq_strobe and dreq_data are driven from registers and stay stable until addr_ok.
- REQ & addr_ok & !data_ok: go to WAIT, drop dreq_valid.
- REQ & addr_ok & data_ok in the same cycle: go straight to FULL, latch valM=dresp_data for LW.
- WAIT & data_ok: go to FULL, latch valM (LW only; SW leaves valM=0).
- data_ok before addr_ok is ignored.
- FULL & out_ready & !in_valid: go to EMPTY.
- FULL & out_ready & in_valid: capture new record; back-to-back throughput is 1/cycle for non-memory ops.
- out_valid = (state==FULL). out_w is held stable while out_valid & !out_ready.
- Incoming stat != OK: treated as non-memory, forwarded unchanged, no bus access.
- Reset mid-transaction: return to EMPTY immediately and drop dreq_valid. A late data_ok after reset is ignored.

Decomposition:
- Shared package (defs.svh) holds:
  - plr_w typedef
  - stat codes, including the new address-error code
  - opcode constants (OP_LW, OP_SW already exist)
  - a mem_state_t enum
- One natural sub-module, mem_bus_fsm: the REQ/WAIT handshake with the bus.
- Record capture and mux stay in mem_stage.

Test Plan:
1. ADDU record in_m.valE=0x0000_0005, out_ready=1 -> out_valid one cycle after capture, out_w.valE=5, valM=0, no dreq_valid ever.
2. LW valE=0x8000_0010; addr_ok on the 2nd REQ cycle, data_ok 3 cycles later with 0xDEAD_BEEF -> dreq_addr stable at 0x8000_0010 until addr_ok, in_ready=0 throughout, then out_w.valM=0xDEAD_BEEF.
3. SW valE=0x100, valA=0x1234_5678, addr_ok and data_ok in the same cycle -> dreq_strobe=4'hF, dreq_data=0x1234_5678, FULL next cycle, valM=0.
4. LW valE=0x0000_0102 -> no dreq_valid, out_w.stat=address-error, 1-cycle latency.
5. Three ADDU back-to-back with out_ready=1 -> one output per cycle; then out_ready=0 for 3 cycles -> out_w held, in_ready=0.
6. Assert reset while in WAIT, deliver data_ok after deassert -> outputs at reset values, data_ok ignored, next ADDU flows normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared record types, stat/opcode codes and memory-stage state enum
package mem_stage_pkg;

    localparam logic [2:0] STAT_OK  = 3'd0;
    localparam logic [2:0] STAT_HLT = 3'd1;
    localparam logic [2:0] STAT_INS = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;

    typedef struct packed {
        logic [4:0]  dstE;
        logic [4:0]  dstM;
        logic [31:0] valA;
        logic [31:0] valE;
        logic [2:0]  stat;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] pc;
    } plr_m;

    typedef struct packed {
        logic [4:0]  dstE;
        logic [4:0]  dstM;
        logic [31:0] valE;
        logic [31:0] valM;
        logic [2:0]  stat;
        logic [5:0]  opcode;
        logic [31:0] pc;
    } plr_w;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FULL  = 2'd3
    } mem_state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_bus_fsm.sv
// rtl/mem_stage_bus_fsm.sv - stage occupancy FSM and registered request/response handshake with the data bus
module mem_bus_fsm
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_mem,
    input  logic        i_store,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_out_ready,
    input  logic        i_addr_ok,
    input  logic        i_data_ok,
    output mem_state_t  o_state,
    output logic        o_done,
    output logic        o_dreq_valid,
    output logic [31:0] o_dreq_addr,
    output logic [3:0]  o_dreq_strobe,
    output logic [31:0] o_dreq_data
);

    mem_state_t  r_state;
    mem_state_t  w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_strobe;

    // state register; reset abandons any in-flight bus transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // next state: data_ok is only honoured once the address phase has been accepted
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (i_load) w_state_nxt = i_mem ? ST_REQ : ST_FULL;
            ST_REQ:   if (i_addr_ok) w_state_nxt = i_data_ok ? ST_FULL : ST_WAIT;
            ST_WAIT:  if (i_data_ok) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (i_out_ready) begin
                    if (i_load) w_state_nxt = i_mem ? ST_REQ : ST_FULL;
                    else        w_state_nxt = ST_EMPTY;
                end
            end
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // request fields are registered at capture so they hold steady until addr_ok
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_strobe <= '0;
        end else if (i_load && i_mem) begin
            r_addr   <= i_addr;
            r_data   <= i_data;
            r_strobe <= i_store ? 4'hF : 4'h0;
        end
    end

    assign o_state       = r_state;
    assign o_done        = ((r_state == ST_REQ) && i_addr_ok && i_data_ok) ||
                           ((r_state == ST_WAIT) && i_data_ok);
    assign o_dreq_valid  = (r_state == ST_REQ);
    assign o_dreq_addr   = r_addr;
    assign o_dreq_strobe = r_strobe;
    assign o_dreq_data   = r_data;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: captures execute record, performs LW/SW bus access, presents write-back record
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  plr_m        in_m,
    output logic        out_valid,
    input  logic        out_ready,
    output plr_w        out_w,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data
);

    mem_state_t w_state;
    logic       w_done;
    logic       w_is_mem;
    logic       w_misalign;
    logic       w_go_bus;
    logic       w_capture;
    logic       w_unused_funct;
    plr_w       r_rec;

    // faulted records (stat != OK) bypass the bus like any non-memory op
    assign w_is_mem   = (in_m.stat == STAT_OK) && is_mem_op(in_m.opcode);
    assign w_misalign = (ADDR_ALIGN_CHECK != 0) && (in_m.valE[1:0] != 2'b00);
    assign w_go_bus   = w_is_mem && !w_misalign;
    assign in_ready   = (w_state == ST_EMPTY) || ((w_state == ST_FULL) && out_ready);
    assign w_capture  = in_valid && in_ready;

    assign w_unused_funct = ^in_m.funct;

    mem_bus_fsm u_bus (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_capture),
        .i_mem         (w_go_bus),
        .i_store       (in_m.opcode == OP_SW),
        .i_addr        (in_m.valE),
        .i_data        (in_m.valA),
        .i_out_ready   (out_ready),
        .i_addr_ok     (dresp_addr_ok),
        .i_data_ok     (dresp_data_ok),
        .o_state       (w_state),
        .o_done        (w_done),
        .o_dreq_valid  (dreq_valid),
        .o_dreq_addr   (dreq_addr),
        .o_dreq_strobe (dreq_strobe),
        .o_dreq_data   (dreq_data)
    );

    // record capture; valM is filled in only when a load completes on the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rec <= '0;
        end else if (w_capture) begin
            r_rec.dstE   <= in_m.dstE;
            r_rec.dstM   <= in_m.dstM;
            r_rec.valE   <= in_m.valE;
            r_rec.valM   <= '0;
            r_rec.stat   <= (w_is_mem && w_misalign) ? STAT_ADR : in_m.stat;
            r_rec.opcode <= in_m.opcode;
            r_rec.pc     <= in_m.pc;
        end else if (w_done && (r_rec.opcode == OP_LW)) begin
            r_rec.valM <= dresp_data;
        end
    end

    assign out_valid = (w_state == ST_FULL);
    assign out_w     = r_rec;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with directed and randomized stimulus
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    plr_m        in_m;
    plr_w        out_w;
    logic        dreq_valid, dresp_addr_ok, dresp_data_ok;
    logic [31:0] dreq_addr, dreq_data, dresp_data;
    logic [3:0]  dreq_strobe;

    int checks = 0;
    int errors = 0;

    bit          m_hold, m_done, m_acc, m_mem;
    plr_w        m_rec;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_ALIGN_CHECK(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m),
        .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic plr_m mk(input logic [5:0] op, input logic [31:0] ve, input logic [31:0] va,
                                input logic [2:0] st);
        plr_m m;
        m.dstE   = 5'($urandom);
        m.dstM   = 5'($urandom);
        m.valA   = va;
        m.valE   = ve;
        m.stat   = st;
        m.opcode = op;
        m.funct  = (op == OP_RTYPE) ? FUNCT_ADDU : 6'($urandom);
        m.pc     = $urandom;
        return m;
    endfunction

    function automatic bit exp_in_ready();
        return !m_hold || (m_done && out_ready);
    endfunction

    task automatic model_reset();
        m_hold = 0; m_done = 0; m_acc = 0; m_mem = 0; m_rec = '0;
    endtask

    // compare every observable output against what the model says the stage holds
    task automatic model_check();
        bit exp_req;
        chk("in_ready", in_ready, exp_in_ready());
        chk("out_valid", out_valid, m_hold && m_done);
        if (m_hold && m_done) chk("out_w", out_w, m_rec);
        exp_req = m_hold && m_mem && !m_acc && !m_done;
        chk("dreq_valid", dreq_valid, exp_req);
        if (exp_req) begin
            chk("dreq_addr", dreq_addr, m_addr);
            chk("dreq_strobe", dreq_strobe, m_strb);
            chk("dreq_data", dreq_data, m_data);
        end
    endtask

    // advance the model across the coming clock edge using the inputs now applied
    task automatic model_update();
        bit take;
        bit is_mem, mis;
        take = in_valid && exp_in_ready();
        if (m_hold && m_mem && !m_done) begin
            if (!m_acc) begin
                if (dresp_addr_ok) begin
                    m_acc = 1;
                    if (dresp_data_ok) begin
                        m_done = 1;
                        if (m_rec.opcode == OP_LW) m_rec.valM = dresp_data;
                    end
                end
            end else if (dresp_data_ok) begin
                m_done = 1;
                if (m_rec.opcode == OP_LW) m_rec.valM = dresp_data;
            end
        end else if (m_hold && m_done && out_ready) begin
            m_hold = 0;
        end
        if (take) begin
            is_mem = (in_m.stat == STAT_OK) && (in_m.opcode == OP_LW || in_m.opcode == OP_SW);
            mis    = in_m.valE[1:0] != 2'b00;
            m_hold = 1;
            m_mem  = is_mem && !mis;
            m_done = !m_mem;
            m_acc  = 0;
            m_rec.dstE   = in_m.dstE;
            m_rec.dstM   = in_m.dstM;
            m_rec.valE   = in_m.valE;
            m_rec.valM   = 32'd0;
            m_rec.stat   = (is_mem && mis) ? STAT_ADR : in_m.stat;
            m_rec.opcode = in_m.opcode;
            m_rec.pc     = in_m.pc;
            m_addr = in_m.valE;
            m_data = in_m.valA;
            m_strb = (in_m.opcode == OP_SW) ? 4'hF : 4'h0;
        end
    endtask

    task automatic step(input logic iv, input plr_m im, input logic ordy, input logic aok,
                        input logic dok, input logic [31:0] dd);
        @(negedge clk);
        in_valid = iv; in_m = im; out_ready = ordy;
        dresp_addr_ok = aok; dresp_data_ok = dok; dresp_data = dd;
        #1;
        model_check();
        model_update();
    endtask

    plr_m nop;
    plr_m r;
    logic [5:0]  rop;
    logic [31:0] rve;

    initial begin
        nop = '0;
        reset = 1'b1; in_valid = 0; in_m = '0; out_ready = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
        model_reset();
        @(negedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dreq_valid", dreq_valid, 1'b0);
        chk("rst_dreq_strobe", dreq_strobe, 4'h0);
        chk("rst_out_w", out_w, 115'd0);
        @(negedge clk); reset = 1'b0;

        // ADDU: one-cycle latency, no bus activity
        step(1, mk(OP_RTYPE, 32'h5, 32'h0, STAT_OK), 1, 0, 0, 0);
        step(0, nop, 1, 0, 0, 0);
        chk("addu_valid", out_valid, 1'b1);
        chk("addu_valE", out_w.valE, 32'h5);
        chk("addu_valM", out_w.valM, 32'h0);

        // LW: addr_ok on 2nd REQ cycle, data_ok 3 cycles later
        step(1, mk(OP_LW, 32'h8000_0010, 32'h0, STAT_OK), 1, 0, 0, 0);
        step(0, nop, 1, 0, 1, 32'h1111_1111);
        chk("lw_addr1", dreq_addr, 32'h8000_0010);
        chk("lw_ready1", in_ready, 1'b0);
        step(0, nop, 1, 1, 0, 0);
        chk("lw_addr2", dreq_addr, 32'h8000_0010);
        chk("lw_strobe", dreq_strobe, 4'h0);
        step(0, nop, 1, 0, 0, 0);
        chk("lw_wait_ready", in_ready, 1'b0);
        step(0, nop, 1, 0, 0, 0);
        step(1, mk(OP_RTYPE, 32'h9, 32'h0, STAT_OK), 1, 0, 1, 32'hDEAD_BEEF);
        chk("lw_wait_ready3", in_ready, 1'b0);
        step(0, nop, 1, 0, 0, 0);
        chk("lw_valM", out_w.valM, 32'hDEAD_BEEF);

        // SW with addr_ok and data_ok together
        step(1, mk(OP_SW, 32'h100, 32'h1234_5678, STAT_OK), 1, 0, 0, 0);
        step(0, nop, 1, 1, 1, 32'h5555_5555);
        chk("sw_strobe", dreq_strobe, 4'hF);
        chk("sw_data", dreq_data, 32'h1234_5678);
        step(0, nop, 1, 0, 0, 0);
        chk("sw_full", out_valid, 1'b1);
        chk("sw_valM", out_w.valM, 32'h0);

        // misaligned LW faults without a bus request
        step(1, mk(OP_LW, 32'h102, 32'h0, STAT_OK), 1, 0, 0, 0);
        step(0, nop, 1, 0, 0, 0);
        chk("mis_valid", out_valid, 1'b1);
        chk("mis_stat", out_w.stat, STAT_ADR);
        chk("mis_dreq", dreq_valid, 1'b0);

        // back-to-back ADDU, then back-pressure
        step(1, mk(OP_RTYPE, 32'h1, 32'h0, STAT_OK), 1, 0, 0, 0);
        step(1, mk(OP_RTYPE, 32'h2, 32'h0, STAT_OK), 1, 0, 0, 0);
        chk("b2b_1", out_w.valE, 32'h1);
        step(1, mk(OP_RTYPE, 32'h3, 32'h0, STAT_OK), 1, 0, 0, 0);
        chk("b2b_2", out_w.valE, 32'h2);
        for (int i = 0; i < 3; i++) begin
            step(1, mk(OP_RTYPE, 32'h4, 32'h0, STAT_OK), 0, 0, 0, 0);
            chk("hold_valE", out_w.valE, 32'h3);
            chk("hold_ready", in_ready, 1'b0);
        end
        step(0, nop, 1, 0, 0, 0);
        step(0, nop, 1, 0, 0, 0);

        // reset while waiting for data, then a stale data_ok
        step(1, mk(OP_LW, 32'h200, 32'h0, STAT_OK), 1, 0, 0, 0);
        step(0, nop, 1, 1, 0, 0);
        step(0, nop, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_dreq_valid", dreq_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_out_w", out_w, 115'd0);
        model_reset();
        @(negedge clk); reset = 1'b0;
        step(0, nop, 1, 0, 1, 32'hBAD0_BAD0);
        step(0, nop, 1, 0, 0, 0);
        chk("late_dok_valid", out_valid, 1'b0);
        step(1, mk(OP_RTYPE, 32'h77, 32'h0, STAT_OK), 1, 0, 0, 0);
        step(0, nop, 1, 0, 0, 0);
        chk("post_rst_valE", out_w.valE, 32'h77);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       rop = OP_LW;
                1:       rop = OP_SW;
                2:       rop = OP_RTYPE;
                default: rop = OP_ADDIU;
            endcase
            rve = $urandom;
            if ($urandom_range(0, 3) != 0) rve[1:0] = 2'b00;
            r = mk(rop, rve, $urandom, ($urandom_range(0, 7) == 0) ? STAT_HLT : STAT_OK);
            step($urandom_range(0, 9) < 6, r, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
